// File: rtl/dtmf_dial_sequencer_pkg.sv
// Shared types and constants for the DTMF dial sequencer: FSM states, tone
// half-period divisors and the key-to-divisor lookup.
package dtmf_pkg;

   localparam int KEY_W  = 4;
   localparam int DIVC_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Half-period divisors in 1 MHz clock cycles
   localparam logic [DIVC_W-1:0] ROW_697  = 10'd717;
   localparam logic [DIVC_W-1:0] ROW_770  = 10'd649;
   localparam logic [DIVC_W-1:0] ROW_852  = 10'd587;
   localparam logic [DIVC_W-1:0] ROW_941  = 10'd531;
   localparam logic [DIVC_W-1:0] COL_1209 = 10'd414;
   localparam logic [DIVC_W-1:0] COL_1336 = 10'd374;
   localparam logic [DIVC_W-1:0] COL_1477 = 10'd339;
   localparam logic [DIVC_W-1:0] COL_1633 = 10'd306;

   typedef struct packed {
      logic [DIVC_W-1:0] row;
      logic [DIVC_W-1:0] col;
   } div_pair_t;

   // Key codes: 0-9 digits, 10='*', 11='#', 12-15='A'-'D'
   function automatic div_pair_t key_to_div(input logic [KEY_W-1:0] key);
      div_pair_t d;
      case (key)
         4'd1, 4'd2, 4'd3, 4'd12:   d.row = ROW_697;
         4'd4, 4'd5, 4'd6, 4'd13:   d.row = ROW_770;
         4'd7, 4'd8, 4'd9, 4'd14:   d.row = ROW_852;
         default:                   d.row = ROW_941;
      endcase
      case (key)
         4'd1, 4'd4, 4'd7, 4'd10:   d.col = COL_1209;
         4'd2, 4'd5, 4'd8, 4'd0:    d.col = COL_1336;
         4'd3, 4'd6, 4'd9, 4'd11:   d.col = COL_1477;
         default:                   d.col = COL_1633;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dtmf_dial_sequencer_if.sv
// Key handshake, abort and tone/status outputs of the DTMF dial sequencer.
interface dtmf_dial_sequencer_if;
   import dtmf_pkg::*;

   logic [KEY_W-1:0] digit_code;
   logic             digit_valid;
   logic             digit_ready;
   logic             abort;
   logic             row_tone;
   logic             col_tone;
   logic             busy;
   logic             done;

   modport master (
      output digit_code, digit_valid, abort,
      input  digit_ready, row_tone, col_tone, busy, done
   );

   modport slave (
      input  digit_code, digit_valid, abort,
      output digit_ready, row_tone, col_tone, busy, done
   );
endinterface

// File: rtl/dtmf_dial_sequencer_tone_div.sv
// Square-wave tone generator: counts 0..div-1 and toggles on wrap, so the
// period is 2*div cycles. Output is forced low while disabled.
module dtmf_tone_div #(
   parameter int DIV_W = 10
) (
   input  logic             i_inclk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tone
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_tone;

   always_ff @(posedge i_inclk) begin
      if (i_reset || i_load) begin
         r_cnt  <= '0;
         r_tone <= 1'b0;
      end else if (i_en) begin
         if (r_cnt == i_div - DIV_W'(1)) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end else begin
         r_tone <= 1'b0;
      end
   end

   assign o_tone = r_tone;

endmodule

// File: rtl/dtmf_dial_sequencer.sv
// DTMF dial sequencer: accepts one key at a time and plays it as a timed
// dual-tone burst followed by a silent gap.
//
//   state   | meaning
//   IDLE    | waiting for a key; ready unless the done pulse is showing
//   TONE    | both square waves running for TONE_MS
//   GAP     | silence for GAP_MS, done pulses on exit
module dtmf_dial_sequencer
   import dtmf_pkg::*;
#(
   parameter int CLK_PER_MS = 1000,
   parameter int TONE_MS    = 100,
   parameter int GAP_MS     = 50,
   parameter int DIV_W      = 10
) (
   input  logic              i_inclk,
   input  logic              i_reset,
   dtmf_dial_sequencer_if.slave bus
);

   localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
   localparam logic [15:0]      TONE_LAST = 16'(TONE_MS - 1);
   localparam logic [15:0]      GAP_LAST  = 16'(GAP_MS - 1);

   state_t           r_state;
   logic [PRE_W-1:0] r_presc;
   logic [15:0]      r_ms;
   logic [KEY_W-1:0] r_code;
   logic             r_busy;
   logic             r_done;

   logic      w_ms_tick;
   logic      w_tone_end;
   logic      w_gap_end;
   logic      w_ready;
   logic      w_accept;
   logic      w_tone_en;
   logic      w_row_tone;
   logic      w_col_tone;
   div_pair_t w_divs;

   assign w_ms_tick  = (r_presc == PRE_LAST);
   assign w_tone_end = (r_state == ST_TONE) && w_ms_tick && (r_ms == TONE_LAST);
   assign w_gap_end  = (r_state == ST_GAP)  && w_ms_tick && (r_ms == GAP_LAST);
   // Hold off ready during the done cycle so successive digits keep their gap
   assign w_ready    = (r_state == ST_IDLE) && !i_reset && !r_done;
   assign w_accept   = w_ready && bus.digit_valid && !bus.abort;
   // Dropping enable on the last TONE cycle makes the tones silent with the state change
   assign w_tone_en  = (r_state == ST_TONE) && !w_tone_end && !bus.abort;
   assign w_divs     = key_to_div(r_code);

   always_ff @(posedge i_inclk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_presc <= '0;
         r_ms    <= '0;
         r_code  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_ms    <= '0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_code  <= bus.digit_code;
                     r_state <= ST_TONE;
                     r_busy  <= 1'b1;
                     r_presc <= '0;
                     r_ms    <= '0;
                  end
               end
               ST_TONE, ST_GAP: begin
                  if (w_tone_end) begin
                     r_state <= ST_GAP;
                     r_presc <= '0;
                     r_ms    <= '0;
                  end else if (w_gap_end) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_presc <= '0;
                     r_ms    <= '0;
                  end else if (w_ms_tick) begin
                     r_presc <= '0;
                     r_ms    <= r_ms + 16'd1;
                  end else begin
                     r_presc <= r_presc + PRE_W'(1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   dtmf_tone_div #(.DIV_W(DIV_W)) u_row_div (
      .i_inclk (i_inclk),
      .i_reset (i_reset),
      .i_en    (w_tone_en),
      .i_load  (w_accept),
      .i_div   (DIV_W'(w_divs.row)),
      .o_tone  (w_row_tone)
   );

   dtmf_tone_div #(.DIV_W(DIV_W)) u_col_div (
      .i_inclk (i_inclk),
      .i_reset (i_reset),
      .i_en    (w_tone_en),
      .i_load  (w_accept),
      .i_div   (DIV_W'(w_divs.col)),
      .o_tone  (w_col_tone)
   );

   assign bus.digit_ready = w_ready;
   assign bus.row_tone    = w_row_tone;
   assign bus.col_tone    = w_col_tone;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule
